// File: rtl/external_entity_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : external_entity_arbiter_pkg
//  Brief    : Shared types and constants for the ExternalEntity arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package external_entity_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ISSUE      = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_DONE  = 3'd3,
      S_RESPOND    = 3'd4
   } arb_state_e;

   localparam int ENT_BUSY_CYCLES = 11;

   // Index width for a requester count; a lone requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/external_entity_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : external_entity_arbiter_if
//  Brief    : Requester and ExternalEntity signal bundle for the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface external_entity_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            ReqValid;
   logic [NUM_REQ*DATA_WIDTH-1:0] ReqData;
   logic [NUM_REQ-1:0]            ReqAccept;
   logic [NUM_REQ-1:0]            RespValid;
   logic [DATA_WIDTH-1:0]         RespData;
   logic                          RespError;
   logic                          Busy;
   logic [DATA_WIDTH-1:0]         EntInSignal;
   logic                          EntTrigger;
   logic [DATA_WIDTH-1:0]         EntOutSignal;
   logic                          EntReady;

   modport slave (
      input  ReqValid, ReqData, EntOutSignal, EntReady,
      output ReqAccept, RespValid, RespData, RespError, Busy,
             EntInSignal, EntTrigger
   );

   modport master (
      output ReqValid, ReqData, EntOutSignal, EntReady,
      input  ReqAccept, RespValid, RespData, RespError, Busy,
             EntInSignal, EntTrigger
   );
endinterface
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_picker
//  Brief    : Combinational round-robin pick, searching from last_grant+1.
//  Revision : 1.0  initial release
// ============================================================================
module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_grant_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   logic found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = |req_i;
      found   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int cand;
         cand = (int'(last_grant_i) + k) % NUM_REQ;
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            idx_o         = IDX_W'(cand);
            grant_o[cand] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/external_entity_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : external_entity_arbiter
//  Brief    : Round-robin sharing of one ExternalEntity with timeout abort.
//  Revision : 1.0  initial release
// ============================================================================
module external_entity_arbiter
   import external_entity_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        Clock,
   input  logic                        Reset,
   external_entity_arbiter_if.slave    bus
);

   localparam int ARB_IDX_W = idx_width(NUM_REQ);
   localparam int WDOG_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WDOG_W-1:0]    WDOG_LAST  = WDOG_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ARB_IDX_W-1:0] LAST_INIT  = ARB_IDX_W'(NUM_REQ - 1);

   arb_state_e             state_q, state_d;
   logic [ARB_IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [ARB_IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_WIDTH-1:0]  op_q, op_d;
   logic [WDOG_W-1:0]      wdog_q, wdog_d;
   logic [NUM_REQ-1:0]     accept_q, accept_d;
   logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
   logic                   resp_error_q, resp_error_d;
   logic                   busy_q, busy_d;
   logic [DATA_WIDTH-1:0]  ent_in_q, ent_in_d;
   logic                   trigger_q, trigger_d;

   logic [NUM_REQ-1:0]     pick_grant;
   logic [ARB_IDX_W-1:0]   pick_idx;
   logic                   pick_any;
   logic [NUM_REQ-1:0]     idx_onehot;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (ARB_IDX_W)
   ) u_picker (
      .req_i        (bus.ReqValid),
      .last_grant_i (last_grant_q),
      .grant_o      (pick_grant),
      .idx_o        (pick_idx),
      .any_o        (pick_any)
   );

   always_comb begin
      idx_onehot        = '0;
      idx_onehot[idx_q] = 1'b1;
   end

   // Outputs are computed alongside the transition so each pulse lands in the
   // cycle the FSM occupies the matching state.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      idx_d        = idx_q;
      op_d         = op_q;
      wdog_d       = wdog_q;
      accept_d     = '0;
      resp_valid_d = '0;
      resp_data_d  = '0;
      resp_error_d = 1'b0;
      trigger_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pick_any && bus.EntReady) begin
               accept_d = pick_grant;
               idx_d    = pick_idx;
               op_d     = bus.ReqData[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            trigger_d = 1'b1;
            wdog_d    = '0;
            state_d   = S_WAIT_START;
         end
         S_WAIT_START: begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == WDOG_LAST) begin
               resp_valid_d = idx_onehot;
               resp_error_d = 1'b1;
               state_d      = S_RESPOND;
            end else if (!bus.EntReady) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            wdog_d = wdog_q + 1'b1;
            if (bus.EntReady) begin
               resp_valid_d = idx_onehot;
               resp_data_d  = bus.EntOutSignal;
               state_d      = S_RESPOND;
            end else if (wdog_q == WDOG_LAST) begin
               resp_valid_d = idx_onehot;
               resp_error_d = 1'b1;
               state_d      = S_RESPOND;
            end
         end
         S_RESPOND: begin
            last_grant_d = idx_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d   = (state_d != S_IDLE);
      ent_in_d = (state_d == S_IDLE) ? '0 : op_d;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= LAST_INIT;
         idx_q        <= '0;
         op_q         <= '0;
         wdog_q       <= '0;
         accept_q     <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
         busy_q       <= 1'b0;
         ent_in_q     <= '0;
         trigger_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         idx_q        <= idx_d;
         op_q         <= op_d;
         wdog_q       <= wdog_d;
         accept_q     <= accept_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
         busy_q       <= busy_d;
         ent_in_q     <= ent_in_d;
         trigger_q    <= trigger_d;
      end
   end

   assign bus.ReqAccept   = accept_q;
   assign bus.RespValid   = resp_valid_q;
   assign bus.RespData    = resp_data_q;
   assign bus.RespError   = resp_error_q;
   assign bus.Busy        = busy_q;
   assign bus.EntInSignal = ent_in_q;
   assign bus.EntTrigger  = trigger_q;

endmodule
`default_nettype wire

// File: tb/tb_external_entity_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_external_entity_arbiter
//  Brief    : Directed bench with an inline ExternalEntity model and hang stub.
//  Revision : 1.0  initial release
// ============================================================================
module tb_external_entity_arbiter;
   import external_entity_arbiter_pkg::*;

   localparam int NUM_REQ        = 4;
   localparam int DATA_WIDTH     = 8;
   localparam int TIMEOUT_CYCLES = 64;

   logic Clock;
   logic Reset;
   logic hang_mode;

   int errors = 0;
   int checks = 0;

   external_entity_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

   external_entity_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .DATA_WIDTH     (DATA_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ExternalEntity: busy for ENT_BUSY_CYCLES, then OutSignal = InSignal + counter.
   logic                  ent_ready;
   logic [DATA_WIDTH-1:0] ent_op;
   logic [DATA_WIDTH-1:0] ent_cnt;
   logic [DATA_WIDTH-1:0] ent_out;

   always @(posedge Clock) begin
      if (Reset) begin
         ent_ready <= 1'b1;
         ent_op    <= '0;
         ent_cnt   <= '0;
         ent_out   <= '0;
      end else if (ent_ready) begin
         if (bus.EntTrigger && !hang_mode) begin
            ent_ready <= 1'b0;
            ent_cnt   <= '0;
            ent_op    <= bus.EntInSignal;
         end
      end else if (ent_cnt == DATA_WIDTH'(ENT_BUSY_CYCLES - 1)) begin
         ent_ready <= 1'b1;
         ent_out   <= ent_op + ent_cnt;
      end else begin
         ent_cnt <= ent_cnt + 1'b1;
      end
   end

   assign bus.EntReady     = ent_ready;
   assign bus.EntOutSignal = ent_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_accept"},  32'(bus.ReqAccept),   32'd0);
      chk({pfx, "_rvalid"},  32'(bus.RespValid),   32'd0);
      chk({pfx, "_rdata"},   32'(bus.RespData),    32'd0);
      chk({pfx, "_rerror"},  32'(bus.RespError),   32'd0);
      chk({pfx, "_busy"},    32'(bus.Busy),        32'd0);
      chk({pfx, "_ent_in"},  32'(bus.EntInSignal), 32'd0);
      chk({pfx, "_trigger"}, 32'(bus.EntTrigger),  32'd0);
   endtask

   task automatic wait_accept(output logic [NUM_REQ-1:0] acc);
      int n;
      n = 0;
      while (bus.ReqAccept == '0 && n < 300) begin
         @(negedge Clock);
         n++;
      end
      acc = bus.ReqAccept;
      chk("accept_seen", 32'(acc != '0), 32'd1);
   endtask

   // From the accept cycle: trigger one cycle later, then one response pulse.
   task automatic finish_op(input int idx, input logic [7:0] data,
                            input logic err, input int lat);
      int n;
      @(negedge Clock);
      chk("trigger", 32'(bus.EntTrigger), 32'd1);
      n = 1;
      while (bus.RespValid == '0 && n < 300) begin
         @(negedge Clock);
         n++;
      end
      chk("latency",    32'(n),             32'(lat));
      chk("resp_valid", 32'(bus.RespValid), 32'(1 << idx));
      chk("resp_data",  32'(bus.RespData),  32'(data));
      chk("resp_error", 32'(bus.RespError), 32'(err));
      @(negedge Clock);
      chk("resp_pulse", 32'(bus.RespValid), 32'd0);
   endtask

   initial begin
      logic [NUM_REQ-1:0] acc;
      int                 n;
      logic               seen;

      Reset       = 1'b1;
      hang_mode   = 1'b0;
      bus.ReqValid = '0;
      bus.ReqData  = '0;
      repeat (3) @(negedge Clock);
      chk_outputs_zero("reset");
      Reset = 1'b0;
      @(negedge Clock);

      // All four requesting: strict rotation starting at requester 0.
      bus.ReqData  = {8'h30, 8'h20, 8'h10, 8'h00};
      bus.ReqValid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_accept(acc);
         chk("rr_grant", 32'(acc), 32'(1 << (k % 4)));
         if (k == 4) bus.ReqValid = '0;
         finish_op(k % 4, 8'h0A + 8'(16 * (k % 4)), 1'b0, 14);
      end

      // Single request on requester 2.
      bus.ReqData[23:16] = 8'h05;
      bus.ReqValid       = 4'b0100;
      wait_accept(acc);
      chk("single_grant",  32'(acc),             32'h4);
      chk("single_ent_in", 32'(bus.EntInSignal), 32'h05);
      chk("single_busy",   32'(bus.Busy),        32'd1);
      bus.ReqValid = '0;
      finish_op(2, 8'h0F, 1'b0, 14);
      chk("idle_busy", 32'(bus.Busy), 32'd0);

      // Hung entity: watchdog abort, TIMEOUT_CYCLES after entering WAIT_START.
      hang_mode         = 1'b1;
      bus.ReqData[7:0]  = 8'h33;
      bus.ReqValid      = 4'b0001;
      wait_accept(acc);
      chk("hang_grant", 32'(acc), 32'h1);
      bus.ReqValid = '0;
      finish_op(0, 8'h00, 1'b1, TIMEOUT_CYCLES + 1);
      hang_mode = 1'b0;

      // Wrap-around result, also proves service resumes after the abort.
      bus.ReqData[15:8] = 8'hFA;
      bus.ReqValid      = 4'b0010;
      wait_accept(acc);
      chk("wrap_grant", 32'(acc), 32'h2);
      bus.ReqValid = '0;
      finish_op(1, 8'h04, 1'b0, 14);

      // Reset during WAIT_DONE drops the request and restores requester-0 priority.
      bus.ReqData[23:16] = 8'h40;
      bus.ReqValid       = 4'b0100;
      wait_accept(acc);
      chk("pre_reset_grant", 32'(acc), 32'h4);
      bus.ReqValid = '0;
      repeat (7) @(negedge Clock);
      chk("pre_reset_busy", 32'(bus.Busy), 32'd1);
      Reset = 1'b1;
      @(negedge Clock);
      chk_outputs_zero("midreset");
      Reset = 1'b0;
      seen  = 1'b0;
      for (n = 0; n < 30; n++) begin
         @(negedge Clock);
         if (bus.RespValid != '0) seen = 1'b1;
      end
      chk("no_resp_after_reset", 32'(seen), 32'd0);
      bus.ReqData  = {8'h77, 8'h00, 8'h00, 8'h20};
      bus.ReqValid = 4'b1001;
      wait_accept(acc);
      chk("post_reset_grant", 32'(acc), 32'h1);
      bus.ReqValid = '0;
      finish_op(0, 8'h2A, 1'b0, 14);

      // Request raised while busy is accepted only after an IDLE cycle.
      bus.ReqData[7:0] = 8'h01;
      bus.ReqValid     = 4'b0001;
      wait_accept(acc);
      chk("busy_req_grant0", 32'(acc), 32'h1);
      bus.ReqValid = '0;
      @(negedge Clock);
      chk("busy_req_trigger", 32'(bus.EntTrigger), 32'd1);
      repeat (4) @(negedge Clock);
      chk("busy_req_inflight", 32'(bus.Busy), 32'd1);
      bus.ReqData[31:24] = 8'h50;
      bus.ReqValid       = 4'b1000;
      n = 0;
      while (bus.RespValid == '0 && n < 300) begin
         @(negedge Clock);
         n++;
      end
      chk("busy_req_resp_time", 32'(n),             32'd9);
      chk("busy_req_resp0",     32'(bus.RespValid), 32'h1);
      chk("busy_req_data0",     32'(bus.RespData),  32'h0B);
      chk("busy_req_accept_r",  32'(bus.ReqAccept), 32'd0);
      @(negedge Clock);
      chk("busy_req_accept_idle", 32'(bus.ReqAccept), 32'd0);
      @(negedge Clock);
      chk("busy_req_accept3", 32'(bus.ReqAccept), 32'h8);
      bus.ReqValid = '0;
      finish_op(3, 8'h5A, 1'b0, 14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
